// File: rtl/fare_pkg.sv
// rtl/fare_pkg.sv - shared types, coin table and BCD constants for the fare block
package fare_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_CHANGE,
    ST_DONE
  } fare_state_t;

  localparam logic [2:0] COIN_Y1   = 3'd0;
  localparam logic [2:0] COIN_Y5   = 3'd1;
  localparam logic [2:0] COIN_Y10  = 3'd2;
  localparam logic [2:0] COIN_Y20  = 3'd3;
  localparam logic [2:0] COIN_Y50  = 3'd4;
  localparam logic [2:0] COIN_Y100 = 3'd5;

  localparam int BCD_SAT = 999;

  function automatic logic [6:0] coin_value(input logic [2:0] code);
    case (code)
      COIN_Y1:   return 7'd1;
      COIN_Y5:   return 7'd5;
      COIN_Y10:  return 7'd10;
      COIN_Y20:  return 7'd20;
      COIN_Y50:  return 7'd50;
      COIN_Y100: return 7'd100;
      default:   return 7'd0;
    endcase
  endfunction

  function automatic logic coin_ok(input logic [2:0] code);
    return code <= COIN_Y100;
  endfunction

endpackage

// File: rtl/fare_payment_if.sv
// rtl/fare_payment_if.sv - passenger/operator signal bundle of the fare block
interface fare_payment_if #(parameter int PRICE_W = 10);

  logic               finish;
  logic [PRICE_W-1:0] price;
  logic               coin_valid;
  logic [2:0]         coin_code;
  logic               cancel;
  logic               ack;
  logic [PRICE_W-1:0] due;
  logic [11:0]        due_bcd;
  logic               bcd_valid;
  logic [PRICE_W:0]   paid;
  logic [PRICE_W-1:0] change;
  logic               change_valid;
  logic               refund;
  logic               coin_reject;
  logic               busy;
  logic               done;

  modport slave (
    input  finish, price, coin_valid, coin_code, cancel, ack,
    output due, due_bcd, bcd_valid, paid, change, change_valid,
           refund, coin_reject, busy, done
  );

  modport master (
    output finish, price, coin_valid, coin_code, cancel, ack,
    input  due, due_bcd, bcd_valid, paid, change, change_valid,
           refund, coin_reject, busy, done
  );

endinterface

// File: rtl/fare_payment_bin2bcd_seq.sv
// rtl/fare_payment_bin2bcd_seq.sv - iterative shift-add-3 binary to 3-digit BCD
module bin2bcd_seq #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         valid,
  output logic [11:0]  bcd
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]    work_bin;
  logic [11:0]     work_bcd;
  logic [11:0]     adj_bcd;
  logic [11:0]     bcd_r;
  logic [11+W:0]   step_next;
  logic [CW-1:0]   cnt;
  logic            busy_r;
  logic            valid_r;

  always_comb begin
    adj_bcd = work_bcd;
    for (int i = 0; i < 3; i++) begin
      if (work_bcd[4*i +: 4] >= 4'd5) adj_bcd[4*i +: 4] = work_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Input is saturated to 999 upstream, so the top bit shifted out is always zero.
  assign step_next = {adj_bcd, work_bin} << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      work_bin <= '0;
      work_bcd <= '0;
      cnt      <= '0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b1;
      bcd_r    <= '0;
    end else if (start) begin
      work_bin <= bin;
      work_bcd <= '0;
      cnt      <= CW'(W);
      busy_r   <= 1'b1;
      valid_r  <= 1'b0;
    end else if (busy_r) begin
      work_bcd <= step_next[11+W:W];
      work_bin <= step_next[W-1:0];
      cnt      <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy_r  <= 1'b0;
        valid_r <= 1'b1;
        bcd_r   <= step_next[11+W:W];
      end
    end
  end

  assign busy  = busy_r;
  assign valid = valid_r;
  assign bcd   = bcd_r;

endmodule

// File: rtl/fare_payment.sv
// rtl/fare_payment.sv - taxi fare collection: coin accumulation, change/refund, BCD due display
module fare_payment
  import fare_pkg::*;
#(
  parameter int PRICE_W = 10
) (
  input  logic          clk,
  input  logic          reset,
  fare_payment_if.slave bus
);

  localparam int PW1 = PRICE_W + 1;

  fare_state_t        state, state_next;
  logic [PRICE_W-1:0] fare_r, change_r;
  logic [PW1-1:0]     paid_r, fare_ext, paid_sum, paid_after, settle_diff, due_diff;
  logic               refund_r, change_valid_r, coin_reject_r, coin_accept;

  assign fare_ext    = {1'b0, fare_r};
  assign coin_accept = bus.coin_valid && coin_ok(bus.coin_code);
  assign paid_sum    = paid_r + PW1'(coin_value(bus.coin_code));
  assign paid_after  = coin_accept ? paid_sum : paid_r;
  assign settle_diff = paid_r - fare_ext;
  assign due_diff    = fare_ext - paid_r;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (bus.finish) state_next = ST_COLLECT;
      ST_COLLECT: begin
        // A zero fare satisfies paid_after >= fare_ext at once.
        if (bus.cancel)                  state_next = ST_DONE;
        else if (paid_after >= fare_ext) state_next = ST_CHANGE;
      end
      ST_CHANGE:  state_next = ST_DONE;
      ST_DONE:    if (bus.ack) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fare_r         <= '0;
      paid_r         <= '0;
      change_r       <= '0;
      refund_r       <= 1'b0;
      change_valid_r <= 1'b0;
      coin_reject_r  <= 1'b0;
    end else begin
      change_valid_r <= 1'b0;
      coin_reject_r  <= 1'b0;
      case (state)
        ST_IDLE: begin
          coin_reject_r <= bus.coin_valid;
          if (bus.finish) begin
            fare_r   <= bus.price;
            paid_r   <= '0;
            change_r <= '0;
            refund_r <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (bus.cancel) begin
            // paid < fare while collecting, so it fits the change width.
            change_r       <= paid_r[PRICE_W-1:0];
            refund_r       <= 1'b1;
            change_valid_r <= 1'b1;
            coin_reject_r  <= bus.coin_valid;
          end else if (bus.coin_valid) begin
            if (coin_accept) paid_r <= paid_sum;
            else             coin_reject_r <= 1'b1;
          end
        end
        ST_CHANGE: begin
          change_r       <= settle_diff[PRICE_W-1:0];
          change_valid_r <= 1'b1;
          coin_reject_r  <= bus.coin_valid;
        end
        default: coin_reject_r <= bus.coin_valid;
      endcase
    end
  end

  logic [PRICE_W-1:0] due_w, due_q, due_sat;
  logic               due_changed, conv_busy, conv_valid;
  logic [11:0]        conv_bcd;

  assign due_w = (state != ST_IDLE && paid_r < fare_ext) ? due_diff[PRICE_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) due_q <= '0;
    else       due_q <= due_w;
  end

  assign due_changed = (due_w != due_q);
  assign due_sat     = (due_w > PRICE_W'(BCD_SAT)) ? PRICE_W'(BCD_SAT) : due_w;

  bin2bcd_seq #(.W(PRICE_W)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (due_changed),
    .bin   (due_sat),
    .busy  (conv_busy),
    .valid (conv_valid),
    .bcd   (conv_bcd)
  );

  assign bus.due          = due_w;
  assign bus.due_bcd      = conv_bcd;
  assign bus.bcd_valid    = conv_valid && !conv_busy && !due_changed;
  assign bus.paid         = paid_r;
  assign bus.change       = change_r;
  assign bus.change_valid = change_valid_r;
  assign bus.refund       = refund_r;
  assign bus.coin_reject  = coin_reject_r;
  assign bus.busy         = (state == ST_COLLECT) || (state == ST_CHANGE);
  assign bus.done         = (state == ST_DONE);

endmodule

// File: tb/tb_fare_payment.sv
// tb/tb_fare_payment.sv - directed bench with a transaction-level fare model
module tb_fare_payment;

  localparam int PW = 10;
  localparam int P_IDLE = 0, P_PAY = 1, P_SETTLE = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fare_payment_if #(.PRICE_W(PW)) bus ();

  fare_payment #(.PRICE_W(PW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  int coin_tab[8] = '{1, 5, 10, 20, 50, 100, 0, 0};

  int m_fare = 0, m_paid = 0, m_change = 0, m_phase = P_IDLE;
  bit m_refund = 0, m_cv = 0, m_rej = 0, m_rst = 1;

  function automatic int model_due();
    if (m_phase == P_IDLE || m_paid >= m_fare) return 0;
    return m_fare - m_paid;
  endfunction

  int prev_due = 0;
  int since = 0;

  always begin
    @(posedge clk);
    m_rst = rst;
    if (rst) begin
      m_fare = 0; m_paid = 0; m_change = 0; m_phase = P_IDLE;
      m_refund = 0; m_cv = 0; m_rej = 0;
    end else begin
      m_cv = 0;
      m_rej = 0;
      case (m_phase)
        P_IDLE: begin
          m_rej = bus.coin_valid;
          if (bus.finish) begin
            m_fare = int'(bus.price); m_paid = 0; m_change = 0; m_refund = 0;
            m_phase = P_PAY;
          end
        end
        P_PAY: begin
          if (bus.cancel) begin
            m_change = m_paid; m_refund = 1; m_cv = 1; m_phase = P_DONE;
            m_rej = bus.coin_valid;
          end else begin
            if (bus.coin_valid) begin
              if (bus.coin_code < 6) m_paid += coin_tab[bus.coin_code];
              else m_rej = 1;
            end
            if (m_paid >= m_fare) m_phase = P_SETTLE;
          end
        end
        P_SETTLE: begin
          m_change = m_paid - m_fare; m_cv = 1; m_phase = P_DONE;
          m_rej = bus.coin_valid;
        end
        default: begin
          m_rej = bus.coin_valid;
          if (bus.ack) m_phase = P_IDLE;
        end
      endcase
    end
    #2;
    check("busy", int'(bus.busy), int'(m_phase == P_PAY || m_phase == P_SETTLE));
    check("done", int'(bus.done), int'(m_phase == P_DONE));
    check("paid", int'(bus.paid), m_paid);
    check("due", int'(bus.due), model_due());
    check("change", int'(bus.change), m_change);
    check("change_valid", int'(bus.change_valid), int'(m_cv));
    check("refund", int'(bus.refund), int'(m_refund));
    check("coin_reject", int'(bus.coin_reject), int'(m_rej));
    if (m_rst) begin
      check("bcd_valid_reset", int'(bus.bcd_valid), 1);
      check("due_bcd_reset", int'(bus.due_bcd), 0);
      since = 0;
      prev_due = 0;
    end else begin
      if (model_due() != prev_due) begin
        check("bcd_drop", int'(bus.bcd_valid), 0);
        since = 0;
      end else begin
        since++;
      end
      if (bus.bcd_valid)
        check("due_bcd", int'(bus.due_bcd), to_bcd(model_due() > 999 ? 999 : model_due()));
      if (since >= PW + 2) check("bcd_latency", int'(bus.bcd_valid), 1);
      prev_due = model_due();
    end
  end

  task automatic cyc(input bit f, input int p, input bit cv, input int code,
                     input bit c, input bit a, input bit r);
    @(negedge clk);
    rst            = r;
    bus.finish     = f;
    bus.price      = PW'(p);
    bus.coin_valid = cv;
    bus.coin_code  = 3'(code);
    bus.cancel     = c;
    bus.ack        = a;
  endtask

  task automatic idle(input int n, input int p);
    repeat (n) cyc(0, p, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, pulses;
    bit got;
    rst = 1'b1;
    bus.finish = 0; bus.price = '0; bus.coin_valid = 0;
    bus.coin_code = '0; bus.cancel = 0; bus.ack = 0;
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);
    check("rst_paid", int'(bus.paid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_bcd_valid", int'(bus.bcd_valid), 1);
    check("rst_due_bcd", int'(bus.due_bcd), 0);
    idle(2, 0);

    // fare 13, pay 10 + 5
    cyc(1, 13, 0, 0, 0, 0, 0);
    cyc(0, 13, 1, 2, 0, 0, 0);
    cyc(0, 13, 1, 1, 0, 0, 0);
    lat = 0; got = 0;
    for (int k = 1; k <= 6 && !got; k++) begin
      idle(1, 13);
      if (bus.change_valid) begin got = 1; lat = k; end
    end
    check("t1_latency", lat, 2);
    check("t1_paid", int'(bus.paid), 15);
    check("t1_change", int'(bus.change), 2);
    check("t1_refund", int'(bus.refund), 0);
    check("t1_done", int'(bus.done), 1);
    idle(14, 13);
    cyc(0, 13, 0, 0, 0, 1, 0);
    idle(2, 13);

    // zero fare
    cyc(1, 0, 0, 0, 0, 0, 0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      idle(1, 0);
      pulses += int'(bus.change_valid);
    end
    check("t2_pulses", pulses, 1);
    check("t2_change", int'(bus.change), 0);
    check("t2_done", int'(bus.done), 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle(2, 0);

    // fare 27, coin 20, cancel
    cyc(1, 27, 0, 0, 0, 0, 0);
    cyc(0, 27, 1, 3, 0, 0, 0);
    idle(14, 27);
    check("t3_due", int'(bus.due), 7);
    check("t3_due_bcd", int'(bus.due_bcd), 'h007);
    cyc(0, 27, 0, 0, 1, 0, 0);
    idle(1, 27);
    check("t3_change", int'(bus.change), 20);
    check("t3_refund", int'(bus.refund), 1);
    idle(5, 27);
    check("t3_due_frozen", int'(bus.due), 7);
    cyc(0, 27, 0, 0, 0, 1, 0);
    idle(1, 27);
    check("t3_due_idle", int'(bus.due), 0);
    idle(14, 27);

    // rejected coins: code 2 in IDLE, code 7 in COLLECT
    cyc(0, 50, 1, 2, 0, 0, 0);
    idle(1, 50);
    check("t4_rej_idle", int'(bus.coin_reject), 1);
    check("t4_paid_idle", int'(bus.paid), 20);
    cyc(1, 50, 0, 0, 0, 0, 0);
    cyc(0, 50, 1, 7, 0, 0, 0);
    idle(1, 50);
    check("t4_rej_bad", int'(bus.coin_reject), 1);
    check("t4_paid_bad", int'(bus.paid), 0);
    cyc(0, 50, 0, 0, 1, 0, 0);
    idle(2, 50);
    cyc(0, 50, 0, 0, 0, 1, 0);
    idle(14, 50);

    // cancel collides with coin 100 after paid 5
    cyc(1, 40, 0, 0, 0, 0, 0);
    cyc(0, 40, 1, 1, 0, 0, 0);
    cyc(0, 40, 1, 5, 1, 0, 0);
    idle(1, 40);
    check("t5_reject", int'(bus.coin_reject), 1);
    check("t5_change", int'(bus.change), 5);
    check("t5_refund", int'(bus.refund), 1);
    check("t5_paid", int'(bus.paid), 5);
    cyc(0, 40, 0, 0, 0, 1, 0);
    idle(14, 40);

    // fare 999, 3 x 100, reset mid-collect, then fare 1023
    cyc(1, 999, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 999, 1, 5, 0, 0, 0);
    idle(14, 999);
    check("t6_due", int'(bus.due), 699);
    check("t6_due_bcd", int'(bus.due_bcd), 'h699);
    cyc(0, 999, 0, 0, 0, 0, 1);
    cyc(0, 999, 0, 0, 0, 0, 0);
    check("t6_rst_busy", int'(bus.busy), 0);
    check("t6_rst_paid", int'(bus.paid), 0);
    check("t6_rst_bcd", int'(bus.due_bcd), 0);
    check("t6_rst_bcd_valid", int'(bus.bcd_valid), 1);
    cyc(1, 1023, 0, 0, 0, 0, 0);
    idle(14, 1023);
    check("t6_due_max", int'(bus.due), 1023);
    check("t6_bcd_sat", int'(bus.due_bcd), 'h999);
    check("t6_bcd_valid", int'(bus.bcd_valid), 1);
    idle(2, 1023);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
